// File: rtl/bitplane_packer.sv
// Collects K unsigned samples from a valid/ready stream and transposes them into the
// bit-plane frame loaded by the bit-serial accumulator; fill and hold buffers overlap frames.
module bitplane_packer #(
  parameter int unsigned M = 3,
  parameter int unsigned N = 2,
  parameter int unsigned K = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  input  logic [M+N-1:0]         in_data,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic                   acc_ready,
  output logic                   pl,
  output logic [(M+N)*K-1:0]     dout,
  output logic                   hold_valid
);

  localparam int unsigned WIDTH = M + N;
  localparam int unsigned CW    = $clog2(K + 1);

  logic [CW-1:0]               cnt_q, cnt_d;
  logic [K-1:0][WIDTH-1:0]     fill_q, fill_d;
  logic [WIDTH*K-1:0]          hold_q, hold_d;
  logic                        hold_valid_q, hold_valid_d;
  logic                        holdoff_q, holdoff_d;
  logic                        accept;
  logic                        xfer;

  assign in_ready   = (cnt_q < CW'(K));
  assign pl         = hold_valid_q & acc_ready & ~holdoff_q;
  assign accept     = in_valid & in_ready;
  assign xfer       = (cnt_q == CW'(K)) & (~hold_valid_q | pl);
  assign dout       = hold_q;
  assign hold_valid = hold_valid_q;

  // Fill, flush, fill->hold transfer and issue bookkeeping
  always_comb begin
    fill_d       = fill_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    holdoff_d    = pl;

    if (accept) begin
      for (int unsigned j = 0; j < K; j++) begin
        if (cnt_q == CW'(j)) fill_d[j] = in_data;
      end
      cnt_d = cnt_q + CW'(1);
    end

    // Flush sees the count after a same-edge accept; a just-completed frame ignores it
    if (flush && (cnt_d != '0) && (cnt_d != CW'(K))) begin
      for (int unsigned j = 0; j < K; j++) begin
        if (CW'(j) >= cnt_d) fill_d[j] = '0;
      end
      cnt_d = CW'(K);
    end

    if (pl) hold_valid_d = 1'b0;

    // Transfer may refill hold on the same edge it is being loaded
    if (xfer) begin
      for (int unsigned j = 0; j < K; j++) begin
        for (int unsigned b = 0; b < WIDTH; b++) begin
          hold_d[b*K+j] = fill_q[j][b];
        end
      end
      hold_valid_d = 1'b1;
      fill_d       = '0;
      cnt_d        = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q        <= '0;
      fill_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      holdoff_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      fill_q       <= fill_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      holdoff_q    <= holdoff_d;
    end
  end

endmodule

// File: tb/tb_bitplane_packer.sv
// Randomized bench for bitplane_packer: a frame-level queue model predicts every issued
// frame (transposed from accepted samples) and the bench compares it on each load pulse.
module tb_bitplane_packer;

  localparam int unsigned M = 3;
  localparam int unsigned N = 2;
  localparam int unsigned K = 4;
  localparam int unsigned W = M + N;

  logic           clk;
  logic           rstn;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic           flush;
  logic           acc_ready;
  logic           pl;
  logic [W*K-1:0] dout;
  logic           hold_valid;

  int vectors = 0;
  int errors  = 0;

  logic [W-1:0]   cur[$];
  logic [W*K-1:0] exp_q[$];
  logic [W*K-1:0] obs_q[$];
  logic           pl_prev = 1'b0;
  int             adj_viol = 0;

  bitplane_packer #(.M(M), .N(N), .K(K)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .acc_ready  (acc_ready),
    .pl         (pl),
    .dout       (dout),
    .hold_valid (hold_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record load pulses mid-cycle, then return 1 time unit after the next rising edge
  task automatic tick();
    @(negedge clk);
    if (rstn && pl) begin
      obs_q.push_back(dout);
      if (pl_prev) adj_viol++;
    end
    pl_prev = rstn && pl;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Frame model: collected samples become dout[b*K+j] = bit b of sample j
  task automatic close_frame();
    logic [W*K-1:0] f;
    logic [W-1:0]   s;
    f = '0;
    while (cur.size() < K) cur.push_back('0);
    for (int j = 0; j < K; j++) begin
      s = cur[j];
      for (int b = 0; b < W; b++) f[b*K+j] = s[b];
    end
    exp_q.push_back(f);
    cur.delete();
  endtask

  task automatic send(input logic [W-1:0] d, input logic fl);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    flush    = fl;
    for (int n = 0; n < 64 && !ok; n++) begin
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: sample %0d not accepted within 64 cycles", d);
    end else begin
      cur.push_back(d);
      if (cur.size() == K || fl) close_frame();
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    if (cur.size() > 0) close_frame();
  endtask

  task automatic test_reset();
    logic [W*K-1:0] want;
    want = '0;
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; acc_ready = 1'b1;
    #1;
    vectors++;
    if (pl !== 1'b0) begin errors++; $display("FAIL reset_pl: got %b want 0", pl); end
    vectors++;
    if (hold_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid: got %b want 0", hold_valid); end
    vectors++;
    if (dout !== want) begin errors++; $display("FAIL reset_dout: got %h want %h", dout, want); end
    ticks(2);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [W*K-1:0] got, want;
    acc_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(W'(i), 1'b0);
    vectors++;
    if (pl !== 1'b0) begin errors++; $display("FAIL basic_pl_early: got %b want 0", pl); end
    tick();
    vectors++;
    if (pl !== 1'b1 || hold_valid !== 1'b1)
      begin errors++; $display("FAIL basic_pl_latency: pl=%b hold_valid=%b want 1,1", pl, hold_valid); end
    tick();
    vectors++;
    if (pl !== 1'b0 || hold_valid !== 1'b0)
      begin errors++; $display("FAIL basic_after_pl: pl=%b hold_valid=%b want 0,0", pl, hold_valid); end
    ticks(4);
    vectors++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL basic_pl_count: got %0d want 1", obs_q.size()); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      vectors++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL basic_frame: got %h want none", got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin errors++; $display("FAIL basic_frame: got %h want %h", got, want); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W*K-1:0] got, want;
    acc_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(W'($urandom), 1'b0);
    vectors++;
    if (in_ready !== 1'b0 || hold_valid !== 1'b1 || pl !== 1'b0)
      begin errors++; $display("FAIL bp_stall: in_ready=%b hold_valid=%b pl=%b want 0,1,0", in_ready, hold_valid, pl); end
    ticks(3);
    vectors++;
    if (in_ready !== 1'b0 || obs_q.size() != 0)
      begin errors++; $display("FAIL bp_hold: in_ready=%b pulses=%0d want 0,0", in_ready, obs_q.size()); end
    acc_ready = 1'b1;
    ticks(12);
    vectors++;
    if (obs_q.size() != 2 || adj_viol != 0)
      begin errors++; $display("FAIL bp_release: pulses=%0d adjacent=%0d want 2,0", obs_q.size(), adj_viol); end
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready: got %b want 1", in_ready); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      vectors++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL bp_frame: got %h want none", got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin errors++; $display("FAIL bp_frame: got %h want %h", got, want); end
      end
    end
  endtask

  task automatic test_stream();
    logic [W*K-1:0] got, want;
    acc_ready = 1'b1;
    for (int i = 0; i < 3 * K; i++) send(W'($urandom), 1'b0);
    ticks(10);
    vectors++;
    if (obs_q.size() != 3 || adj_viol != 0 || exp_q.size() != 3)
      begin errors++; $display("FAIL stream_pulses: pulses=%0d adjacent=%0d expected_frames=%0d want 3,0,3", obs_q.size(), adj_viol, exp_q.size()); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      vectors++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL stream_frame: got %h want none", got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin errors++; $display("FAIL stream_frame: got %h want %h", got, want); end
      end
    end
  endtask

  task automatic test_flush();
    logic [W*K-1:0] got, want;
    acc_ready = 1'b1;
    send(W'(5), 1'b0);
    send(W'(7), 1'b0);
    do_flush();
    ticks(6);
    vectors++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL flush_pulses: got %0d want 1", obs_q.size()); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      vectors++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL flush_frame: got %h want none", got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin errors++; $display("FAIL flush_frame: got %h want %h", got, want); end
      end
    end
    do_flush();
    ticks(6);
    vectors++;
    if (obs_q.size() != 0 || hold_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_empty: pulses=%0d hold_valid=%b in_ready=%b want 0,0,1", obs_q.size(), hold_valid, in_ready); end
  endtask

  task automatic test_flush_edge();
    logic [W*K-1:0] got, want;
    acc_ready = 1'b1;
    for (int i = 0; i < K - 1; i++) send(W'($urandom), 1'b0);
    send(W'($urandom), 1'b1);
    ticks(6);
    vectors++;
    if (obs_q.size() != 1 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_last_pulses: pulses=%0d in_ready=%b want 1,1", obs_q.size(), in_ready); end
    for (int i = 0; i < K - 2; i++) send(W'($urandom), 1'b0);
    send(W'($urandom), 1'b1);
    ticks(6);
    vectors++;
    if (obs_q.size() != 2 || exp_q.size() != 2)
      begin errors++; $display("FAIL flush_third_pulses: pulses=%0d expected_frames=%0d want 2,2", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      vectors++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL flush_edge_frame: got %h want none", got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin errors++; $display("FAIL flush_edge_frame: got %h want %h", got, want); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W*K-1:0] got, want, zero;
    zero = '0;
    acc_ready = 1'b0;
    for (int i = 0; i < K + 2; i++) send(W'($urandom), 1'b0);
    vectors++;
    if (hold_valid !== 1'b1) begin errors++; $display("FAIL rmid_held: hold_valid=%b want 1", hold_valid); end
    #1;
    rstn = 1'b0;
    acc_ready = 1'b1;
    #1;
    vectors++;
    if (pl !== 1'b0 || hold_valid !== 1'b0 || dout !== zero)
      begin errors++; $display("FAIL rmid_async: pl=%b hold_valid=%b dout=%h want 0,0,0", pl, hold_valid, dout); end
    exp_q.delete();
    cur.delete();
    obs_q.delete();
    pl_prev = 1'b0;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || pl !== 1'b0)
      begin errors++; $display("FAIL rmid_release: in_ready=%b pl=%b want 1,0", in_ready, pl); end
    for (int i = 0; i < K; i++) send(W'($urandom), 1'b0);
    ticks(6);
    vectors++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL rmid_pulses: got %0d want 1", obs_q.size()); end
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      vectors++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL rmid_frame: got %h want none", got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin errors++; $display("FAIL rmid_frame: got %h want %h", got, want); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stream();
    test_flush();
    test_flush_edge();
    test_reset_mid();
    vectors++;
    if (adj_viol != 0) begin errors++; $display("FAIL pl_adjacent: got %0d adjacent pulses want 0", adj_viol); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
